rca8_mp_seq: RTL and testbench

Multi-precision add sequencer. It accepts NBYTES-wide operands through a valid/ready handshake and feeds them LSB-byte-first through a single 8-bit ripple-carry adder, chaining the carry between cycles. It returns the full-width sum, carry-out and signed overflow through a second valid/ready handshake. It sits between the operand source and result consumer wherever wide adds must reuse the one 8-bit adder datapath instead of a full-width adder.

---
 rtl/rca_seq_pkg.sv | 12 +
 rtl/rca_8.sv | 24 ++
 rtl/rca8_mp_seq.sv | 119 +++++++++++
 tb/tb_rca8_mp_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package rca_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rca_8.sv
// 8-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module rca_8
  import rca_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o
);

  logic [BYTE_W:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[BYTE_W];
  end

endmodule

// File: rtl/rca8_mp_seq.sv
// Multi-precision add sequencer: streams NBYTES-wide operands LSB byte first
// through a single 8-bit ripple-carry adder, chaining the carry across cycles.
module rca8_mp_seq
  import rca_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int unsigned W  = BYTE_W * NBYTES;
  localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  seq_state_t state_q, state_d;

  logic [W-1:0]      a_q, b_q, sum_q, sum_d;
  logic [KW-1:0]     k_q;
  logic              carry_q, cout_q, ovf_q;
  logic [BYTE_W-1:0] byte_a, byte_b, byte_s;
  logic              byte_co;
  logic              accept, last_byte, ovf_d;

  assign accept    = in_ready && in_valid && !clr;
  assign last_byte = (k_q == K_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clr overrides every transition
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid)  state_d = RUN;
        RUN:     if (last_byte) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign byte_a = a_q[k_q*BYTE_W +: BYTE_W];
  assign byte_b = b_q[k_q*BYTE_W +: BYTE_W];

  rca_8 u_rca_8 (
    .a_i    (byte_a),
    .b_i    (byte_b),
    .cin_i  (carry_q),
    .sum_o  (byte_s),
    .cout_o (byte_co)
  );

  // Merge the current byte into the running sum; ovf uses the final MSB
  always_comb begin
    sum_d = sum_q;
    sum_d[k_q*BYTE_W +: BYTE_W] = byte_s;
    ovf_d = byte_co ^ (a_q[W-1] ^ b_q[W-1] ^ byte_s[BYTE_W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= cin;
    end else if (!clr && state_q == RUN) begin
      sum_q   <= sum_d;
      carry_q <= byte_co;
      k_q     <= KW'(k_q + 1'b1);
      if (last_byte) begin
        cout_q <= byte_co;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca8_mp_seq.sv
// Directed bench for rca8_mp_seq with a scoreboard of expected results.
module tb_rca8_mp_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [W-1:0] a, b, sum;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rca8_mp_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned sum via wide add, overflow via signed range test
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    exp_t       m;
    logic [W:0] t;
    longint     sa;
    t  = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    sa = longint'($signed(ma));
    sa = sa + longint'($signed(mb));
    if (mc) sa = sa + 1;
    m.s = t[W-1:0];
    m.c = t[W];
    m.v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
    return m;
  endfunction

  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    a        = oa;
    b        = ob;
    cin      = oc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.push_back(model(oa, ob, oc));
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("latency", 64'(cnt), 64'(NB));
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    check({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"},  64'(sum),  64'(e.s));
      check({tag, "_cout"}, 64'(cout), 64'(e.c));
      check({tag, "_ovf"},  64'(ovf),  64'(e.v));
    end
  endtask

  task automatic finish_op(input string tag, input int hold);
    int cnt;
    wait_valid(cnt);
    repeat (hold) tick();
    compare_head(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"},  64'(in_ready),  64'd1);
  endtask

  initial begin
    exp_t e;
    int   cnt;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    rst_n = 1'b1;
    tick();

    // Basic carry into byte 1, ripple through all bytes, signed overflow cases
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0); finish_op("byte_carry", 0);
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1); finish_op("full_ripple", 0);
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); finish_op("pos_ovf", 0);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0); finish_op("neg_ovf", 0);

    // Back-pressure in DONE with a new operand set waiting
    start_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
    wait_valid(cnt);
    e         = sb[0];
    a         = 32'hCAFE_0001;
    b         = 32'h1234_FFFF;
    cin       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready",  64'(in_ready),  64'd0);
      check("hold_sum",       64'(sum),       64'(e.s));
      check("hold_cout",      64'(cout),      64'(e.c));
      check("hold_ovf",       64'(ovf),       64'(e.v));
    end
    compare_head("hold_result");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    start_op(32'hCAFE_0001, 32'h1234_FFFF, 1'b1);
    finish_op("after_hold", 2);

    // Abort with clr while byte 2 is pending
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_in_ready",  64'(in_ready),  64'd1);
    check("clr_out_valid", 64'(out_valid), 64'd0);
    repeat (6) begin
      tick();
      check("clr_no_valid", 64'(out_valid), 64'd0);
    end
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_valid(cnt);
    check("post_clr_sum_const", 64'(sum), 64'h2345_6789);
    compare_head("post_clr");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-RUN
    a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  64'(in_ready),  64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_sum",       64'(sum),       64'd0);
    #2 rst_n = 1'b1;
    tick();
    start_op(32'h89AB_CDEF, 32'h7654_3211, 1'b0); finish_op("post_rst", 0);

    // A few random operand sets with random consumer delay
    for (int i = 0; i < 8; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      finish_op("rand", int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
